// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, instruction capture from ram, and a small {pc, instr} FIFO
// handed to decode over valid/ready, flushed on redirect.
module fetch_unit #(
  parameter int                    ARCH_WIDTH = 32,
  parameter logic [ARCH_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ARCH_WIDTH-1:0] i_addr,
  input  logic [ARCH_WIDTH-1:0] i_data,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [ARCH_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ARCH_WIDTH-1:0] out_instr,
  output logic [ARCH_WIDTH-1:0] out_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic [ARCH_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ARCH_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [ARCH_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic                  push, pop;
  logic                  unused_ok;

  assign unused_ok = ^redirect_pc[1:0];
  assign i_addr    = {2'b00, fetch_pc_q[ARCH_WIDTH-1:2]};
  assign out_valid = count_q != '0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;

  // A redirect squashes the head and blocks both push and pop in its cycle.
  always_comb begin
    pop        = out_valid && out_ready && !redirect_valid;
    push       = fetch_enable && !redirect_valid && (count_q < DEPTH || pop);
    fetch_pc_d = redirect_valid ? {redirect_pc[ARCH_WIDTH-1:2], 2'b00}
               : push ? fetch_pc_q + ARCH_WIDTH'(4) : fetch_pc_q;
    wr_ptr_d   = redirect_valid ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = redirect_valid ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = redirect_valid ? '0
               : (push && !pop) ? count_q + CW'(1)
               : (pop && !push) ? count_q - CW'(1) : count_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= i_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard queue of expected {pc, instr}
// entries; a negedge monitor pops and compares every accepted output.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] i_addr, i_data;
  logic        fetch_enable, redirect_valid, out_valid, out_ready;
  logic [31:0] redirect_pc, out_instr, out_pc;
  logic [63:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  fetch_unit #(.ARCH_WIDTH(32), .RESET_PC(32'h40), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .i_addr(i_addr), .i_data(i_data),
    .fetch_enable(fetch_enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clock = ~clock;
  assign i_data = 32'h1000 + i_addr;

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, 32'h1000 + {2'b00, pc[31:2]}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ent(first + 32'(4 * i)));
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h instr %h expected none", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("stream_pc", out_pc, e[63:32]);
        chk("stream_instr", out_instr, e[31:0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0; fetch_enable = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) cyc();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pc", out_pc, 32'h0);
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_iaddr", i_addr, 32'h10);
    // streaming at one instruction per cycle, then fetch_enable low for 3 cycles
    reset_n = 1'b1; fetch_enable = 1'b1; out_ready = 1'b1;
    expect_pcs(32'h40, 6);
    cyc();
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_pc", out_pc, 32'h40);
    chk("latency_instr", out_instr, 32'h1010);
    repeat (5) cyc();
    fetch_enable = 1'b0;
    repeat (3) cyc();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("frozen_iaddr", i_addr, 32'h16);
    // backpressure: fill to depth 2, then release with no gap or duplicate
    fetch_enable = 1'b1; out_ready = 1'b0;
    expect_pcs(32'h58, 4);
    repeat (5) cyc();
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_head_pc", out_pc, 32'h58);
    chk("full_iaddr", i_addr, 32'h18);
    out_ready = 1'b1;
    repeat (4) cyc();
    // redirect with two entries buffered: both squashed
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    chk("pre_redirect_head", out_pc, 32'h68);
    cyc();
    redirect_valid = 1'b0;
    chk("post_redirect_valid", 32'(out_valid), 32'd0);
    chk("post_redirect_pc", out_pc, 32'h0);
    chk("post_redirect_instr", out_instr, 32'h0);
    chk("redirect_iaddr", i_addr, 32'h40);
    expect_pcs(32'h100, 3);
    cyc();
    chk("target_pc", out_pc, 32'h100);
    chk("target_instr", out_instr, 32'h1040);
    repeat (2) cyc();
    fetch_enable = 1'b0;
    repeat (2) cyc();
    // address wrap at the top of the space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("wrap_iaddr", i_addr, 32'h3FFF_FFFF);
    exp_q.push_back(ent(32'hFFFF_FFFC));
    expect_pcs(32'h0, 2);
    fetch_enable = 1'b1;
    repeat (3) cyc();
    fetch_enable = 1'b0;
    repeat (3) cyc();
    chk("wrap_drain_valid", 32'(out_valid), 32'd0);
    // asynchronous reset between edges while holding two entries
    fetch_enable = 1'b1; out_ready = 1'b0;
    repeat (3) cyc();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_pc", out_pc, 32'h0);
    chk("async_reset_instr", out_instr, 32'h0);
    chk("async_reset_iaddr", i_addr, 32'h10);
    #3 reset_n = 1'b1; out_ready = 1'b1;
    expect_pcs(32'h40, 3);
    cyc();
    chk("restart_pc", out_pc, 32'h40);
    repeat (2) cyc();
    fetch_enable = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction port of ram. It holds the fetch PC, drives i_addr and captures the combinational i_data in the same cycle. Fetched {pc, instr} pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake. It also accepts branch/jump redirects, which flush the buffer.

Parameters:
ARCH_WIDTH, 32, datapath and address width in bits.
RESET_PC, 0, byte address of the first fetch after reset.
FIFO_DEPTH, 2, number of buffered entries; power of two, at least 2.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
i_addr  output  ARCH_WIDTH  word index to ram instruction port.
i_data  input  ARCH_WIDTH  instruction word from ram; valid in the same cycle as i_addr.
fetch_enable  input  1  when 1, fetch is allowed; when 0, the unit halts fetching.
redirect_valid  input  1  one-cycle pulse requesting a PC change.
redirect_pc  input  ARCH_WIDTH  byte target address of the redirect.
out_valid  output  1  the head FIFO entry is valid.
out_ready  input  1  decode accepts the head entry.
out_instr  output  ARCH_WIDTH  instruction at the head entry.
out_pc  output  ARCH_WIDTH  byte PC of the head entry.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset, applied asynchronously and at any time, including mid-stream:
  - fetch_pc = RESET_PC.
  - FIFO count = 0; read and write pointers = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0.
- i_addr is combinational: {2'b00, fetch_pc[ARCH_WIDTH-1:2]}.
- pop = out_valid && out_ready && !redirect_valid.
- push = fetch_enable && !redirect_valid && (count < FIFO_DEPTH || pop).
- On push, at the posedge:
  - Write {fetch_pc, i_data} at the write pointer.
  - fetch_pc += 4, modulo 2^ARCH_WIDTH. 0xFFFFFFFC wraps to 0.
- On pop: advance the read pointer.
- Count update:
  - push and pop together leaves count unchanged, giving a sustained throughput of 1 instruction per cycle while full.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs:
  - out_valid = (count != 0).
  - out_instr and out_pc reflect the head entry combinationally when out_valid = 1, and are driven to 0 when out_valid = 0.
  - Once out_valid is asserted, the head entry is held stable until it is popped or a redirect occurs.
- Latency: the first posedge with reset_n = 1 and fetch_enable = 1 pushes. out_valid rises after that edge, so fetch-to-output latency is 1 cycle.
- Redirect has priority over everything else. At the posedge with redirect_valid = 1:
  - count = 0 and pointers = 0.
  - fetch_pc = {redirect_pc[ARCH_WIDTH-1:2], 2'b00}; the low 2 bits are ignored.
  - No push and no pop occur.
  - Any head entry shown in that cycle is squashed; decode must not commit it, even if out_ready = 1.
  - out_valid is 0 in the next cycle. The target instruction becomes valid 1 cycle later if fetch_enable = 1.
- fetch_enable = 0: no push and fetch_pc holds; buffered entries still drain via pop.
- Full with out_ready = 0: no push, fetch_pc holds, i_addr is stable.
- No stateful read is required from ram; i_addr may change every cycle.

Test Plan:
- Reset release, fetch_enable = 1, out_ready = 1, ram word[n] = 0x1000 + n -> out_valid rises 1 cycle after reset release; out_pc sequence 0, 4, 8, … with out_instr 0x1000, 0x1001, …; one entry accepted per cycle.
- out_ready = 0 for 5 cycles after the first fetch -> count saturates at 2, i_addr holds at 2, head stays pc 0; on out_ready = 1, pcs 0, 4, 8 are delivered with no gap and no duplicate.
- Redirect to 0x0000_0103 while the FIFO holds 2 entries and out_ready = 1 -> the head in the redirect cycle is squashed; out_valid = 0 in the next cycle; the next output is out_pc 0x100 with ram word[0x40].
- fetch_enable toggled low for 3 cycles -> no pushes, fetch_pc frozen, existing entries drain, out_valid falls; the stream resumes at the correct next pc.
- reset_n asserted mid-stream, between edges -> out_valid and outputs go to 0 immediately; after release, fetch restarts at RESET_PC (bench run with RESET_PC = 0x40).
- fetch_pc = 0xFFFF_FFFC via redirect -> out_pc 0xFFFF_FFFC is followed by 0x0000_0000.
